// File: rtl/eth_tx_fcs_ctrl.sv
// TX frame sequencer: passes bytes through, zero-pads short frames to MIN_LEN, appends the FCS, then holds off for the IFG.
// Zero-latency data path (In_Ready follows Out_Ready in DATA); pad and FCS bytes hold steady while Out_Ready is low.
module eth_tx_fcs_ctrl #(
  parameter int MIN_LEN    = 60,
  parameter int PAD_EN     = 1,
  parameter int IFG_CYCLES = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  In_Data,
  input  logic        In_Valid,
  input  logic        In_Last,
  output logic        In_Ready,
  output logic [7:0]  Out_Data,
  output logic        Out_Valid,
  output logic        Out_Last,
  input  logic        Out_Ready,
  output logic        Crc_Init,
  output logic        Crc_En,
  output logic [7:0]  Crc_Data,
  input  logic [31:0] Crc_Value,
  output logic [15:0] Frame_Len,
  output logic        Frame_Done
);

  localparam int            GW        = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);
  localparam logic [15:0]   MIN_LEN_W = 16'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, DATA, PAD, FCS, GAP} state_t;

  state_t        state, state_nxt;
  logic [15:0]   byte_cnt, byte_cnt_inc;
  logic [1:0]    fcs_idx;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    fcs_sel, fcs_byte;

  // The engine shifts MSB-first, so each FCS byte is a bit-reversed, inverted slice of its register.
  always_comb begin
    fcs_sel = 8'h00;
    case (fcs_idx)
      2'd0: fcs_sel = Crc_Value[31:24];
      2'd1: fcs_sel = Crc_Value[23:16];
      2'd2: fcs_sel = Crc_Value[15:8];
      2'd3: fcs_sel = Crc_Value[7:0];
      default: fcs_sel = 8'h00;
    endcase
    fcs_byte = 8'h00;
    for (int i = 0; i < 8; i++) begin
      fcs_byte[i] = ~fcs_sel[7-i];
    end
  end

  always_comb begin
    state_nxt    = state;
    In_Ready     = 1'b0;
    Out_Valid    = 1'b0;
    Out_Last     = 1'b0;
    Out_Data     = 8'h00;
    Crc_En       = 1'b0;
    byte_cnt_inc = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
    case (state)
      IDLE: begin
        if (In_Valid) state_nxt = DATA;
      end
      DATA: begin
        Out_Data  = In_Data;
        Out_Valid = In_Valid;
        In_Ready  = Out_Ready;
        Crc_En    = In_Valid & Out_Ready;
        if (In_Valid && Out_Ready && In_Last)
          state_nxt = (PAD_EN != 0 && byte_cnt_inc < MIN_LEN_W) ? PAD : FCS;
      end
      PAD: begin
        Out_Valid = 1'b1;
        Crc_En    = Out_Ready;
        if (Out_Ready && byte_cnt_inc >= MIN_LEN_W) state_nxt = FCS;
      end
      FCS: begin
        Out_Data  = fcs_byte;
        Out_Valid = 1'b1;
        Out_Last  = (fcs_idx == 2'd3);
        if (Out_Ready && fcs_idx == 2'd3) state_nxt = GAP;
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign Crc_Data = Out_Data;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      byte_cnt   <= 16'd0;
      fcs_idx    <= 2'd0;
      gap_cnt    <= '0;
      Frame_Len  <= 16'd0;
      Frame_Done <= 1'b0;
      Crc_Init   <= 1'b1;
    end else begin
      state      <= state_nxt;
      // Released one cycle ahead so the engine still holds all-ones on the first DATA byte.
      Crc_Init   <= (state_nxt == IDLE) || (state_nxt == GAP);
      Frame_Done <= (state == FCS) && Out_Ready && (fcs_idx == 2'd3);

      if (state == IDLE)
        byte_cnt <= 16'd0;
      else if (Crc_En)
        byte_cnt <= byte_cnt_inc;

      if (state != FCS && state_nxt == FCS)
        Frame_Len <= byte_cnt_inc;

      if (state != FCS)
        fcs_idx <= 2'd0;
      else if (Out_Ready)
        fcs_idx <= fcs_idx + 2'd1;

      if (state == GAP)
        gap_cnt <= gap_cnt + 1'b1;
      else
        gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_eth_tx_fcs_ctrl.sv
// Bench for eth_tx_fcs_ctrl: instance 0 built with PAD_EN=0, instance 1 with PAD_EN=1, each driving its own CRC engine.
module tb_eth_tx_fcs_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_dat;
  logic        in_lst;
  logic        out_rdy;
  logic [1:0]  in_vld, in_rdy, out_vld, out_lst, crc_init, crc_en, frame_done;
  logic [7:0]  out_dat [2];
  logic [7:0]  crc_dat [2];
  logic [15:0] frame_len [2];

  always #5 clk = ~clk;

  // Engine: MSB-first shift register, poly 0x04C11DB7, data bits fed LSB first.
  function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  // Reference: textbook reflected CRC-32 of a whole buffer.
  function automatic logic [31:0] sw_crc32(input logic [7:0] b[$]);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    foreach (b[k]) begin
      r = r ^ {24'd0, b[k]};
      for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return ~r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [31:0] crc_reg;
    eth_tx_fcs_ctrl #(.MIN_LEN(60), .PAD_EN(g), .IFG_CYCLES(12)) u_dut (
      .Clk(clk), .Reset(rst),
      .In_Data(in_dat), .In_Valid(in_vld[g]), .In_Last(in_lst), .In_Ready(in_rdy[g]),
      .Out_Data(out_dat[g]), .Out_Valid(out_vld[g]), .Out_Last(out_lst[g]), .Out_Ready(out_rdy),
      .Crc_Init(crc_init[g]), .Crc_En(crc_en[g]), .Crc_Data(crc_dat[g]), .Crc_Value(crc_reg),
      .Frame_Len(frame_len[g]), .Frame_Done(frame_done[g])
    );
    always @(posedge clk) begin
      if (crc_init[g])     crc_reg <= 32'hFFFFFFFF;
      else if (crc_en[g])  crc_reg <= eng_step(crc_reg, crc_dat[g]);
    end
  end

  int          checks = 0, failures = 0;
  int          xfer_cnt = 0, en_cnt = 0, done_cnt = 0;
  int          gap_meas = 0, last_gap = 0, stall_at = -1, stall_left = 0;
  logic [31:0] last4 = 32'd0;
  logic        prev_stall = 1'b0, prev_last_xfer = 1'b0, measuring = 1'b0, in_xfer = 1'b0;
  logic [9:0]  prev_word = 10'd0;
  logic        sel = 1'b0;
  logic [8:0]  exp_q [$];
  int          len_q [$];
  logic [7:0]  frm [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Expected output for the frame in frm, padded when the selected instance pads.
  task automatic model_frame();
    logic [7:0]  fb [$];
    logic [31:0] c;
    fb = frm;
    if (sel) while (fb.size() < 60) fb.push_back(8'h00);
    c = sw_crc32(fb);
    foreach (fb[k]) exp_q.push_back({1'b0, fb[k]});
    for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), c[8*k +: 8]});
    len_q.push_back(fb.size());
  endtask

  task automatic sample();
    logic s, o, xfer;
    logic [8:0] e;
    s    = sel;
    o    = ~sel;
    xfer = out_vld[s] && out_rdy;
    chk("other_idle", 32'(out_vld[o]), 32'd0);
    chk("done_timing", 32'(frame_done[s]), 32'(prev_last_xfer));
    if (prev_stall)
      chk("hold_stable", 32'({out_vld[s], out_lst[s], out_dat[s]}), 32'(prev_word));
    prev_stall     = out_vld[s] && !out_rdy;
    prev_word      = {out_vld[s], out_lst[s], out_dat[s]};
    prev_last_xfer = xfer && out_lst[s];
    in_xfer        = in_vld[s] && in_rdy[s];
    if (crc_en[s]) begin
      en_cnt++;
      chk("crc_en_is_xfer", 32'(xfer), 32'd1);
      chk("crc_data", 32'(crc_dat[s]), 32'(out_dat[s]));
      chk("crc_init_low", 32'(crc_init[s]), 32'd0);
    end
    if (xfer) begin
      xfer_cnt++;
      last4 = {out_dat[s], last4[31:8]};
      chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_last_data", 32'({out_lst[s], out_dat[s]}), 32'(e));
      end
    end
    if (frame_done[s]) begin
      done_cnt++;
      chk("len_expected", 32'(len_q.size() != 0), 32'd1);
      if (len_q.size() != 0) chk("frame_len", 32'(frame_len[s]), 32'(len_q.pop_front()));
    end
    if (measuring) begin
      if (in_rdy[s]) begin measuring = 1'b0; last_gap = gap_meas; end
      else gap_meas++;
    end
    if (prev_last_xfer) begin measuring = 1'b1; gap_meas = 0; end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk); #1;
    if (stall_left > 0 && xfer_cnt == stall_at) begin out_rdy = 1'b0; stall_left--; end
    else out_rdy = 1'b1;
  endtask

  task automatic send_frame(input bit bubbles, input bit keep_vld);
    int t;
    model_frame();
    for (int i = 0; i < frm.size(); i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_vld[sel] = 1'b0; in_lst = 1'b1; in_dat = 8'($urandom); tick();
      end
      in_vld[sel] = 1'b1; in_dat = frm[i]; in_lst = (i == frm.size() - 1);
      t = 0;
      do begin tick(); t++; end while (!in_xfer && t < 2000);
      chk("in_accept", 32'(in_xfer), 32'd1);
      if (!in_xfer) break;
    end
    if (!keep_vld) begin in_vld[sel] = 1'b0; in_lst = 1'b0; end
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 3000) begin tick(); t++; end
    chk("frame_done_seen", 32'(done_cnt >= target), 32'd1);
    repeat (16) tick();
  endtask

  task automatic reset_checks();
    logic gi;
    for (int g = 0; g < 2; g++) begin
      gi = g[0];
      chk("rst_in_ready", 32'(in_rdy[gi]), 32'd0);
      chk("rst_out_valid", 32'(out_vld[gi]), 32'd0);
      chk("rst_out_last", 32'(out_lst[gi]), 32'd0);
      chk("rst_out_data", 32'(out_dat[gi]), 32'd0);
      chk("rst_crc_en", 32'(crc_en[gi]), 32'd0);
      chk("rst_crc_data", 32'(crc_dat[gi]), 32'd0);
      chk("rst_crc_init", 32'(crc_init[gi]), 32'd1);
      chk("rst_frame_len", 32'(frame_len[gi]), 32'd0);
      chk("rst_frame_done", 32'(frame_done[gi]), 32'd0);
    end
  endtask

  initial begin
    int base, e0, d0, t;
    rst = 1'b1; in_vld = 2'b00; in_dat = 8'h00; in_lst = 1'b0; out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_checks();
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // "123456789" without padding
    sel = 1'b0;
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    chk("model_pin_crc", sw_crc32(frm), 32'hCBF43926);
    base = xfer_cnt; e0 = en_cnt; d0 = done_cnt;
    send_frame(1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("check_fcs_bytes", last4, 32'hCBF43926);
    chk("t1_out_bytes", 32'(xfer_cnt - base), 32'd13);
    chk("t1_frame_len", 32'(frame_len[0]), 32'd9);
    chk("t1_crc_en_cnt", 32'(en_cnt - e0), 32'd9);
    chk("t1_done_once", 32'(done_cnt - d0), 32'd1);

    // 1-byte frame padded to 60
    sel = 1'b1;
    frm.delete(); frm.push_back(8'hAB);
    base = xfer_cnt; e0 = en_cnt; d0 = done_cnt;
    send_frame(1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t2_out_bytes", 32'(xfer_cnt - base), 32'd64);
    chk("t2_frame_len", 32'(frame_len[1]), 32'd60);
    chk("t2_crc_en_cnt", 32'(en_cnt - e0), 32'd60);
    chk("t2_done_once", 32'(done_cnt - d0), 32'd1);

    // exactly MIN_LEN bytes: FCS directly after byte 60
    frm.delete();
    for (int i = 0; i < 60; i++) frm.push_back(8'(i * 7 + 1));
    base = xfer_cnt; e0 = en_cnt; d0 = done_cnt;
    send_frame(1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t3_out_bytes", 32'(xfer_cnt - base), 32'd64);
    chk("t3_crc_en_cnt", 32'(en_cnt - e0), 32'd60);

    // 64 bytes with bubbles, Out_Ready low for 3 cycles on FCS byte 2
    frm.delete();
    for (int i = 0; i < 64; i++) frm.push_back(8'($urandom));
    base = xfer_cnt; e0 = en_cnt; d0 = done_cnt;
    stall_at = base + 66; stall_left = 3;
    send_frame(1'b1, 1'b0);
    wait_done(d0 + 1);
    chk("t4_stall_applied", 32'(stall_left), 32'd0);
    chk("t4_out_bytes", 32'(xfer_cnt - base), 32'd68);
    chk("t4_crc_en_cnt", 32'(en_cnt - e0), 32'd64);
    chk("t4_frame_len", 32'(frame_len[1]), 32'd64);

    // back-to-back frames, In_Valid held high across the gap
    d0 = done_cnt;
    frm.delete();
    for (int i = 0; i < 60; i++) frm.push_back(8'(255 - i));
    send_frame(1'b0, 1'b1);
    frm.delete();
    for (int i = 0; i < 45; i++) frm.push_back(8'(i ^ 8'h5A));
    send_frame(1'b0, 1'b0);
    wait_done(d0 + 2);
    chk("t5_in_ready_gap", 32'(last_gap), 32'd13);
    chk("t5_done_twice", 32'(done_cnt - d0), 32'd2);

    // reset while FCS byte 1 is on the bus
    sel = 1'b0;
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(8'(8'h31 + i));
    base = xfer_cnt;
    send_frame(1'b0, 1'b0);
    t = 0;
    while (xfer_cnt != base + 10 && t < 200) begin tick(); t++; end
    chk("t6_reached_fcs1", 32'(xfer_cnt - base), 32'd10);
    #2 rst = 1'b1;
    #1 reset_checks();
    exp_q.delete(); len_q.delete();
    prev_stall = 1'b0; prev_last_xfer = 1'b0; measuring = 1'b0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    repeat (20) tick();
    chk("t6_no_done_after_abort", 32'(done_cnt - d0), 32'd0);

    base = xfer_cnt; d0 = done_cnt;
    send_frame(1'b0, 1'b0);
    wait_done(d0 + 1);
    chk("t7_fcs_after_reset", last4, 32'hCBF43926);
    chk("t7_out_bytes", 32'(xfer_cnt - base), 32'd13);
    chk("t7_frame_len", 32'(frame_len[0]), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_tx_fcs_ctrl.md
Name: eth_tx_fcs_ctrl

Overview:
TX-side sequencer for the byte-wide CRC-32 engine (crc). It passes an Ethernet frame byte stream (destination MAC through payload, no preamble/SFD) through to the MAC output. It zero-pads short frames to MIN_LEN and appends the 4-byte FCS taken from the CRC engine. It also drives the engine's init and enable inputs and enforces the inter-frame gap before the next frame is accepted.

Parameters:
MIN_LEN, 60, minimum pre-FCS frame length in bytes; padding target
PAD_EN, 1, 1 = pad short frames with 0x00 up to MIN_LEN, 0 = never pad
IFG_CYCLES, 12, idle cycles enforced after the last FCS byte before the next frame is accepted (minimum 1)

Ports:
Clk  input  1  clock
Reset  input  1  asynchronous, active-high reset
In_Data  input  8  frame byte from upstream
In_Valid  input  1  In_Data valid
In_Last  input  1  marks the final frame byte; qualified by In_Valid
In_Ready  output  1  upstream transfer accepted when In_Valid & In_Ready
Out_Data  output  8  byte to the MAC/PHY side
Out_Valid  output  1  Out_Data valid
Out_Last  output  1  high with the final FCS byte
Out_Ready  input  1  downstream accepts when Out_Valid & Out_Ready
Crc_Init  output  1  to the crc Reset input; high holds the CRC at 0xFFFFFFFF
Crc_En  output  1  to the crc Enable input
Crc_Data  output  8  to the crc Data_in input
Crc_Value  input  32  from the crc Crc output
Frame_Len  output  16  pre-FCS length (payload + pad) of the last completed frame
Frame_Done  output  1  one-cycle pulse after the last FCS byte transfers

Behaviour:
- Reset is Reset, asynchronous, active-high; clock is Clk.
- Reset values: state IDLE, Crc_Init=1, Frame_Len=0, Frame_Done=0, all counters 0.
- Reset outputs: In_Ready=0, Out_Valid=0, Out_Last=0, Crc_En=0, Out_Data=0, Crc_Data=0.
- States: IDLE, DATA, PAD, FCS, GAP.
- IDLE:
  - In_Ready=0, Out_Valid=0.
  - If In_Valid=1, go to DATA next cycle.
  - Byte count is cleared.
- DATA:
  - Zero-latency pass-through: Out_Data=In_Data, Out_Valid=In_Valid, In_Ready=Out_Ready.
  - A transfer is a cycle with In_Valid & Out_Ready.
  - In_Valid=0 is a bubble: no transfer and no Crc_En.
  - On a transfer with In_Last=1: go to PAD if PAD_EN=1 and (count+1)<MIN_LEN, otherwise go to FCS.
- PAD:
  - Out_Data=0x00, Out_Valid=1, In_Ready=0.
  - Leave for FCS on the transfer that makes count==MIN_LEN.
- Byte count:
  - 16-bit, increments on every DATA/PAD output transfer.
  - Saturates at 0xFFFF.
  - Copied to Frame_Len on DATA/PAD exit.
- CRC drive:
  - Crc_Data=Out_Data.
  - Crc_En = Out_Valid & Out_Ready while in DATA or PAD; 0 in all other states.
- Crc_Init:
  - Registered.
  - 0 when the next state is DATA, PAD or FCS; 1 when the next state is IDLE or GAP.
  - The CRC register is therefore 0xFFFFFFFF on the first DATA cycle.
- FCS:
  - Crc_Value is stable throughout because Crc_En=0.
  - A 2-bit index n runs 0..3 and advances on each Out_Ready transfer.
  - Out_Data[i] = ~Crc_Value[31-8n-i] for i=0..7. Byte 0 is therefore {~C[24],~C[25],...,~C[31]} MSB-to-LSB.
  - Out_Valid=1; Out_Last=1 when n=3.
  - With Out_Ready=0, Out_Data, Out_Valid and Out_Last hold unchanged.
  - On the n=3 transfer: go to GAP and pulse Frame_Done on the next cycle.
- GAP:
  - In_Ready=0, Out_Valid=0.
  - Counts IFG_CYCLES cycles, then goes to IDLE.
- Boundaries:
  - In_Last on the very first byte gives a 1-byte frame; it is padded if PAD_EN=1.
  - A frame of exactly MIN_LEN bytes gets no pad.
  - In_Last is ignored when In_Valid=0.
  - Reset mid-frame aborts immediately: state IDLE, Crc_Init=1, and no Out_Last or Frame_Done is produced.

Test Plan:
- PAD_EN=0; send ASCII "123456789" (0x31..0x39) with In_Last on 0x39, Out_Ready=1 -> output is 9 bytes passthrough, then 0x26 0x39 0xF4 0xCB with Out_Last on 0xCB; Frame_Len=9; Frame_Done pulses once.
- PAD_EN=1; 1-byte frame 0xAB -> 0xAB, then 59×0x00, then 4 FCS bytes equal to the software CRC-32 of that 60-byte buffer; 64 output bytes total; Frame_Len=60.
- 60-byte frame with PAD_EN=1 -> no PAD state entered; FCS directly follows byte 60.
- 64-byte frame with random In_Valid bubbles and Out_Ready low for 3 cycles during FCS byte 2 -> FCS bytes held stable, none lost or duplicated, Crc_En count=64, FCS matches the model.
- Back-to-back frames with In_Valid held high -> In_Ready stays 0 for exactly IFG_CYCLES=12 cycles after the Out_Last transfer plus 1 IDLE cycle; second frame FCS correct.
- Reset asserted during FCS byte 1 -> outputs return to reset values asynchronously, no Out_Last or Frame_Done; next frame "123456789" again yields 26 39 F4 CB.
